adc_window_avg: RTL and testbench
=================================

ADC_WINDOW_AVG -- requirements
Module: adc_window_avg

Interface
REQ-001 Parameter LOG2_N, default 4, sets the window length to 2^LOG2_N samples; legal range 1..8.
REQ-002 Parameter CAPTURE_DLY, default 4, is the number of clk_i cycles from eoc_i to a valid data_i (DRP read latency); legal range 1..15.
REQ-003 Parameter HYST, default 12'd32, is the threshold hysteresis in LSBs.
REQ-004 There is one clock and reset is synchronous and active-high.
REQ-005 clk_i  in  1  ADC clock; the same clock that drives the XADC DRP.
REQ-006 reset_i  in  1  synchronous, active-high reset.
REQ-007 data_i  in  16  XADC DRP read data; the sample is data_i[15:4].
REQ-008 eoc_i  in  1  XADC end-of-conversion, a one-cycle pulse.
REQ-009 thr_i  in  12  comparator threshold, quasi-static.
REQ-010 avg_o  out  12  mean of the last completed window.
REQ-011 avg_valid_o  out  1  one-cycle pulse; avg_o, min_o, max_o and above_o are updated on this pulse.
REQ-012 min_o / max_o  out  12 each  minimum and maximum sample of the last completed window.
REQ-013 above_o  out  1  threshold comparator output with hysteresis.
REQ-014 overrun_o  out  1  sticky flag; an eoc_i arrived while a capture was pending.

Function
REQ-015 FSM states: IDLE and WAIT; the delay counter is 4 bits wide.
REQ-016 IDLE with eoc_i=1 -> WAIT, counter loaded with CAPTURE_DLY-1; IDLE with eoc_i=0 -> stay in IDLE.
REQ-017 WAIT with counter>0 -> decrement the counter; WAIT with counter==0 -> capture data_i[15:4] on that edge.
REQ-018 The capture edge is the rising edge ending cycle T+CAPTURE_DLY, where eoc_i is high in cycle T.
REQ-019 On capture, go to IDLE; if eoc_i=1 in the capture cycle itself, go directly to WAIT with the counter reloaded, and that eoc_i is accepted without loss.
REQ-020 eoc_i=1 in WAIT with counter>0 is ignored and sets overrun_o.
REQ-021 The accumulator is 12+LOG2_N bits wide and cannot overflow; the sample index is LOG2_N bits wide and wraps to 0.
REQ-022 On a capture with index < 2^LOG2_N-1: add the sample to acc, fold it into the running min/max, and increment the index.
REQ-023 On the final capture of a window:
- avg_o <= (acc+sample)>>LOG2_N, truncating.
- min_o/max_o <= final min/max including the sample.
- acc, min and max restart: acc=0, min=12'hFFF, max=0.
- index wraps to 0.
REQ-024 avg_valid_o is high only in the cycle after the final capture edge, giving latency CAPTURE_DLY+1 cycles from the final eoc_i.
REQ-025 above_o is evaluated only on a window completion, against the new average:
- set when avg >= thr_i;
- cleared when avg < max(thr_i-HYST, 0), saturating;
- otherwise held.
REQ-026 Windows are contiguous and non-overlapping; no samples are dropped other than overrun events.

Reset
REQ-027 While reset_i=1:
- FSM=IDLE, counter=0, index=0, acc=0, running min=12'hFFF, running max=0;
- avg_o=0, min_o=0, max_o=0;
- avg_valid_o=0, above_o=0, overrun_o=0.
REQ-028 Reset mid-window or mid-WAIT discards the partial window and any pending capture; the first eoc_i after reset starts a new window.

Structure
REQ-029 Package adc_pkg holds SAMPLE_W=12, the LOG2_N/CAPTURE_DLY/HYST defaults, and the FSM state enum.
REQ-030 One sub-module, adc_hyst_cmp, holds the hysteresis comparator, registered, enabled by the completion pulse.
REQ-031 The block is instantiated directly downstream of the XADC wrapper on its clock and consumes its data and eoc outputs.

Verification
REQ-032 The bench uses LOG2_N=2, CAPTURE_DLY=4, HYST=32, thr_i=2048.
REQ-033 Four eoc_i pulses 10 cycles apart with samples 100,200,300,401 (data_i=sample<<4) -> avg_o=250, min_o=100, max_o=401, one avg_valid_o pulse 5 cycles after the 4th eoc_i.
REQ-034 Windows averaging 2048, then 2030, then 2015 -> above_o = 1, 1, 0.
REQ-035 eoc_i 2 cycles after a previous eoc_i -> second pulse ignored, overrun_o=1 held until reset, window completes only after 4 accepted captures.
REQ-036 eoc_i asserted exactly in the capture cycle (4 cycles apart) -> both samples accepted, overrun_o stays 0.
REQ-037 reset_i pulsed after 2 captures, then 4 samples of 4095 -> avg_o=4095 with no contamination from pre-reset data; all outputs 0 during reset.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared widths, parameter defaults and FSM encoding for the XADC window averager.
package adc_pkg;
   localparam int              SAMPLE_W        = 12;
   localparam int              LOG2_N_DEF      = 4;
   localparam int              CAPTURE_DLY_DEF = 4;
   localparam logic [11:0]     HYST_DEF        = 12'd32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;
endpackage

// File: rtl/adc_hyst_cmp.sv
// Registered threshold comparator with hysteresis, updated only when en_i pulses.
// Latency 1 cycle from en_i; no backpressure.
module adc_hyst_cmp
   import adc_pkg::*;
#(
   parameter logic [SAMPLE_W-1:0] HYST = HYST_DEF
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                en_i,
   input  logic [SAMPLE_W-1:0] avg_i,
   input  logic [SAMPLE_W-1:0] thr_i,
   output logic                above_o
);

   logic [SAMPLE_W-1:0] thr_low;

   // Lower threshold saturates at zero instead of wrapping for small thresholds.
   assign thr_low = (thr_i >= HYST) ? (thr_i - HYST) : '0;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         above_o <= 1'b0;
      end else if (en_i) begin
         if (avg_i >= thr_i)
            above_o <= 1'b1;
         else if (avg_i < thr_low)
            above_o <= 1'b0;
      end
   end

endmodule

// File: rtl/adc_window_avg.sv
// Windowed mean/min/max of XADC samples with a hysteresis comparator on the mean.
// Latency CAPTURE_DLY+1 cycles from the final eoc_i of a window; no backpressure, early eoc_i is dropped and flagged.
module adc_window_avg
   import adc_pkg::*;
#(
   parameter int                  LOG2_N      = LOG2_N_DEF,
   parameter int                  CAPTURE_DLY = CAPTURE_DLY_DEF,
   parameter logic [SAMPLE_W-1:0] HYST        = HYST_DEF
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [15:0]         data_i,
   input  logic                eoc_i,
   input  logic [SAMPLE_W-1:0] thr_i,
   output logic [SAMPLE_W-1:0] avg_o,
   output logic                avg_valid_o,
   output logic [SAMPLE_W-1:0] min_o,
   output logic [SAMPLE_W-1:0] max_o,
   output logic                above_o,
   output logic                overrun_o
);

   localparam int                ACC_W    = SAMPLE_W + LOG2_N;
   localparam logic [3:0]        DLY_LOAD = 4'(CAPTURE_DLY - 1);
   localparam logic [LOG2_N-1:0] IDX_LAST = '1;

   state_t              state;
   logic [3:0]          cnt;
   logic [LOG2_N-1:0]   idx;
   logic [ACC_W-1:0]    acc;
   logic [SAMPLE_W-1:0] run_min;
   logic [SAMPLE_W-1:0] run_max;

   logic [SAMPLE_W-1:0] sample;
   logic [3:0]          unused_lsbs;
   logic                capture;
   logic                last;
   logic [ACC_W-1:0]    sum;
   logic [SAMPLE_W-1:0] avg_next;
   logic [SAMPLE_W-1:0] min_next;
   logic [SAMPLE_W-1:0] max_next;

   assign sample      = data_i[15:4];
   assign unused_lsbs = data_i[3:0];
   assign capture     = (state == ST_WAIT) && (cnt == 4'd0);
   assign last        = capture && (idx == IDX_LAST);
   assign sum         = acc + ACC_W'(sample);
   assign avg_next    = sum[ACC_W-1:LOG2_N];
   assign min_next    = (sample < run_min) ? sample : run_min;
   assign max_next    = (sample > run_max) ? sample : run_max;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state       <= ST_IDLE;
         cnt         <= 4'd0;
         idx         <= '0;
         acc         <= '0;
         run_min     <= '1;
         run_max     <= '0;
         avg_o       <= '0;
         min_o       <= '0;
         max_o       <= '0;
         avg_valid_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         avg_valid_o <= last;

         case (state)
            ST_IDLE: begin
               if (eoc_i) begin
                  state <= ST_WAIT;
                  cnt   <= DLY_LOAD;
               end
            end
            ST_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
                  if (eoc_i)
                     overrun_o <= 1'b1;
               end else if (eoc_i) begin
                  // A new conversion landing on the capture cycle chains straight into the next wait.
                  cnt <= DLY_LOAD;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (capture) begin
            if (last) begin
               avg_o   <= avg_next;
               min_o   <= min_next;
               max_o   <= max_next;
               acc     <= '0;
               run_min <= '1;
               run_max <= '0;
               idx     <= '0;
            end else begin
               acc     <= sum;
               run_min <= min_next;
               run_max <= max_next;
               idx     <= idx + LOG2_N'(1);
            end
         end
      end
   end

   adc_hyst_cmp #(
      .HYST (HYST)
   ) u_hyst_cmp (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (last),
      .avg_i   (avg_next),
      .thr_i   (thr_i),
      .above_o (above_o)
   );

endmodule

// File: tb/tb_adc_window_avg.sv
// Directed bench for adc_window_avg with LOG2_N=2, CAPTURE_DLY=4, HYST=32, thr=2048.
module tb_adc_window_avg;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [15:0] data_i;
   logic        eoc_i;
   logic [11:0] thr_i;
   logic [11:0] avg_o;
   logic        avg_valid_o;
   logic [11:0] min_o;
   logic [11:0] max_o;
   logic        above_o;
   logic        overrun_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc_n    = 0;
   int          vld_cnt  = 0;
   int          last_vld_cyc = -1;
   int          eoc_cyc  = 0;
   int          vld_before;
   logic [11:0] pipe [4];

   always #5 clk_i = ~clk_i;

   adc_window_avg #(
      .LOG2_N      (2),
      .CAPTURE_DLY (4),
      .HYST        (12'd32)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .data_i      (data_i),
      .eoc_i       (eoc_i),
      .thr_i       (thr_i),
      .avg_o       (avg_o),
      .avg_valid_o (avg_valid_o),
      .min_o       (min_o),
      .max_o       (max_o),
      .above_o     (above_o),
      .overrun_o   (overrun_o)
   );

   always @(negedge clk_i) begin
      if (avg_valid_o) begin
         vld_cnt      <= vld_cnt + 1;
         last_vld_cyc <= cyc_n;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One clock cycle; data_i models the DRP returning the sample four cycles after its eoc.
   task automatic cyc(input logic e, input logic [11:0] s);
      eoc_i  = e;
      data_i = {pipe[3], 4'h0};
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = s;
      if (e) eoc_cyc = cyc_n;
      @(posedge clk_i);
      #1;
      cyc_n++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 12'd0);
   endtask

   task automatic send(input logic [11:0] s);
      cyc(1'b1, s);
      idle(9);
   endtask

   initial begin
      reset_i = 1'b1;
      eoc_i   = 1'b0;
      data_i  = 16'h0;
      thr_i   = 12'd2048;
      for (int i = 0; i < 4; i++) pipe[i] = 12'd0;

      idle(3);
      check("rst_avg", avg_o, 0);
      check("rst_min", min_o, 0);
      check("rst_max", max_o, 0);
      check("rst_vld", avg_valid_o, 0);
      check("rst_above", above_o, 0);
      check("rst_overrun", overrun_o, 0);
      reset_i = 1'b0;
      idle(2);

      // Basic window: 100,200,300,401 -> 1001/4 = 250
      send(12'd100);
      send(12'd200);
      send(12'd300);
      send(12'd401);
      check("w1_avg", avg_o, 250);
      check("w1_min", min_o, 100);
      check("w1_max", max_o, 401);
      check("w1_vld_cnt", vld_cnt, 1);
      check("w1_latency", last_vld_cyc - eoc_cyc, 5);
      check("w1_above", above_o, 0);

      // Hysteresis: 2048 sets, 2030 holds, 2015 clears (low threshold 2016)
      for (int i = 0; i < 4; i++) send(12'd2048);
      check("h1_avg", avg_o, 2048);
      check("h1_above", above_o, 1);
      for (int i = 0; i < 4; i++) send(12'd2030);
      check("h2_avg", avg_o, 2030);
      check("h2_above", above_o, 1);
      for (int i = 0; i < 4; i++) send(12'd2015);
      check("h3_avg", avg_o, 2015);
      check("h3_above", above_o, 0);
      check("h_vld_cnt", vld_cnt, 4);

      // eoc exactly on the capture cycle: 500,600,700,803 -> 2603/4 = 650
      cyc(1'b1, 12'd500); idle(3);
      cyc(1'b1, 12'd600); idle(3);
      cyc(1'b1, 12'd700); idle(3);
      cyc(1'b1, 12'd803); idle(9);
      check("b2b_avg", avg_o, 650);
      check("b2b_min", min_o, 500);
      check("b2b_max", max_o, 803);
      check("b2b_vld_cnt", vld_cnt, 5);
      check("b2b_overrun", overrun_o, 0);

      // Overrun: second eoc 2 cycles after the first is dropped
      cyc(1'b1, 12'd1000); idle(1);
      cyc(1'b1, 12'd4000); idle(7);
      check("ovr_flag", overrun_o, 1);
      send(12'd1004);
      send(12'd1008);
      check("ovr_no_early_vld", vld_cnt, 5);
      send(12'd1012);
      check("ovr_vld_cnt", vld_cnt, 6);
      check("ovr_avg", avg_o, 1006);
      check("ovr_min", min_o, 1000);
      check("ovr_max", max_o, 1012);
      check("ovr_sticky", overrun_o, 1);

      // Reset mid-window with a capture pending
      send(12'd10);
      send(12'd20);
      cyc(1'b1, 12'd30); idle(1);
      reset_i = 1'b1;
      idle(2);
      check("mid_rst_avg", avg_o, 0);
      check("mid_rst_min", min_o, 0);
      check("mid_rst_max", max_o, 0);
      check("mid_rst_vld", avg_valid_o, 0);
      check("mid_rst_overrun", overrun_o, 0);
      reset_i = 1'b0;
      idle(6);
      vld_before = vld_cnt;
      for (int i = 0; i < 4; i++) send(12'd4095);
      check("post_rst_avg", avg_o, 4095);
      check("post_rst_min", min_o, 4095);
      check("post_rst_max", max_o, 4095);
      check("post_rst_above", above_o, 1);
      check("post_rst_vld", vld_cnt - vld_before, 1);
      check("post_rst_overrun", overrun_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
